// File: rtl/muller_c_handshake_driver.sv
// 4-phase handshake master for a Muller C-element: drives two skewed requests,
// watches the synchronized C output for hold violations and timeouts, counts handshakes.
module muller_c_handshake_driver #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 200,
  parameter int TMO_W       = 8,
  parameter int CNT_W       = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             enable_i,
  input  logic [3:0]       skew_i,
  input  logic             clear_i,
  input  logic             c_out_i,
  output logic             req_a_o,
  output logic             req_b_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] done_cnt_o,
  output logic             err_hold_o,
  output logic             err_timeout_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RISE_A = 3'd1,
    ST_RISE_B = 3'd2,
    ST_FALL_A = 3'd3,
    ST_FALL_B = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t                 state_r, state_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   c_sync_s;
  logic [3:0]             skew_cnt_r, skew_cnt_s;
  logic [3:0]             skew_lat_r, skew_lat_s;
  logic [TMO_W-1:0]       tmo_cnt_r, tmo_cnt_s;
  logic [CNT_W-1:0]       done_cnt_r, done_cnt_s;
  logic                   req_a_r, req_a_s;
  logic                   req_b_r, req_b_s;
  logic                   busy_r, busy_s;
  logic                   err_hold_r, err_hold_s;
  logic                   err_tmo_r, err_tmo_s;

  assign c_sync_s = sync_r[SYNC_STAGES-1];

  // Synchronizer chain for the asynchronous C-element output
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], c_out_i};
    end
  end

  // Next-state and next-output decode of the handshake sequencer
  always_comb begin
    state_s    = state_r;
    skew_cnt_s = skew_cnt_r;
    skew_lat_s = skew_lat_r;
    tmo_cnt_s  = tmo_cnt_r;
    done_cnt_s = done_cnt_r;
    req_a_s    = req_a_r;
    req_b_s    = req_b_r;
    err_hold_s = err_hold_r;
    err_tmo_s  = err_tmo_r;
    case (state_r)
      ST_IDLE: begin
        if (enable_i) begin
          state_s    = ST_RISE_A;
          req_a_s    = 1'b1;
          req_b_s    = 1'b0;
          skew_cnt_s = skew_i;
          skew_lat_s = skew_i;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RISE_A: begin
        // Only req_a has moved, so any rise of the C output is a hold violation
        if (c_sync_s) begin
          state_s    = ST_ERROR;
          err_hold_s = 1'b1;
          req_a_s    = 1'b0;
          req_b_s    = 1'b0;
        end else if (skew_cnt_r == 4'd0) begin
          state_s   = ST_RISE_B;
          req_b_s   = 1'b1;
          tmo_cnt_s = {TMO_W{1'b0}};
        end else begin
          skew_cnt_s = skew_cnt_r - 4'd1;
        end
      end
      ST_RISE_B: begin
        if (c_sync_s) begin
          state_s    = ST_FALL_A;
          req_a_s    = 1'b0;
          skew_cnt_s = skew_lat_r;
        end else if (tmo_cnt_r == TMO_LAST) begin
          state_s   = ST_ERROR;
          err_tmo_s = 1'b1;
          req_a_s   = 1'b0;
          req_b_s   = 1'b0;
        end else begin
          tmo_cnt_s = tmo_cnt_r + TMO_ONE;
        end
      end
      ST_FALL_A: begin
        if (!c_sync_s) begin
          state_s    = ST_ERROR;
          err_hold_s = 1'b1;
          req_a_s    = 1'b0;
          req_b_s    = 1'b0;
        end else if (skew_cnt_r == 4'd0) begin
          state_s   = ST_FALL_B;
          req_b_s   = 1'b0;
          tmo_cnt_s = {TMO_W{1'b0}};
        end else begin
          skew_cnt_s = skew_cnt_r - 4'd1;
        end
      end
      ST_FALL_B: begin
        if (!c_sync_s) begin
          done_cnt_s = done_cnt_r + CNT_ONE;
          if (enable_i) begin
            state_s    = ST_RISE_A;
            req_a_s    = 1'b1;
            skew_cnt_s = skew_i;
            skew_lat_s = skew_i;
          end else begin
            state_s = ST_IDLE;
          end
        end else if (tmo_cnt_r == TMO_LAST) begin
          state_s   = ST_ERROR;
          err_tmo_s = 1'b1;
          req_a_s   = 1'b0;
          req_b_s   = 1'b0;
        end else begin
          tmo_cnt_s = tmo_cnt_r + TMO_ONE;
        end
      end
      ST_ERROR: begin
        req_a_s = 1'b0;
        req_b_s = 1'b0;
        if (clear_i) begin
          state_s    = ST_IDLE;
          err_hold_s = 1'b0;
          err_tmo_s  = 1'b0;
        end else begin
          state_s = ST_ERROR;
        end
      end
      default: begin
        state_s = ST_IDLE;
        req_a_s = 1'b0;
        req_b_s = 1'b0;
      end
    endcase
    busy_s = (state_s != ST_IDLE) && (state_s != ST_ERROR);
  end

  // State, counters and registered outputs
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r    <= ST_IDLE;
      skew_cnt_r <= 4'd0;
      skew_lat_r <= 4'd0;
      tmo_cnt_r  <= {TMO_W{1'b0}};
      done_cnt_r <= {CNT_W{1'b0}};
      req_a_r    <= 1'b0;
      req_b_r    <= 1'b0;
      busy_r     <= 1'b0;
      err_hold_r <= 1'b0;
      err_tmo_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      skew_cnt_r <= skew_cnt_s;
      skew_lat_r <= skew_lat_s;
      tmo_cnt_r  <= tmo_cnt_s;
      done_cnt_r <= done_cnt_s;
      req_a_r    <= req_a_s;
      req_b_r    <= req_b_s;
      busy_r     <= busy_s;
      err_hold_r <= err_hold_s;
      err_tmo_r  <= err_tmo_s;
    end
  end

  assign req_a_o       = req_a_r;
  assign req_b_o       = req_b_r;
  assign busy_o        = busy_r;
  assign done_cnt_o    = done_cnt_r;
  assign err_hold_o    = err_hold_r;
  assign err_timeout_o = err_tmo_r;

endmodule

// File: tb/tb_muller_c_handshake_driver.sv
// Bench for muller_c_handshake_driver: C-element models (good / faulty), table-driven
// handshakes, randomized skews against a timeline model, and error/reset corner cases.
module tb_muller_c_handshake_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable_i;
  logic [3:0] skew_i;
  logic       clear_i;
  logic [1:0] fault_mode;

  logic        c_out1, req_a1, req_b1, busy1, hold1, tmo1;
  logic [15:0] done1;
  logic        c_out2, req_a2, req_b2, busy2, hold2, tmo2;
  logic [1:0]  done2;
  logic        c_good1, c_good2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  muller_c_handshake_driver dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable_i(enable_i), .skew_i(skew_i),
    .clear_i(clear_i), .c_out_i(c_out1), .req_a_o(req_a1), .req_b_o(req_b1),
    .busy_o(busy1), .done_cnt_o(done1), .err_hold_o(hold1), .err_timeout_o(tmo1)
  );

  // Narrow-counter instance used to observe wrap-around
  muller_c_handshake_driver #(.CNT_W(2)) dut_w (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable_i(enable_i), .skew_i(skew_i),
    .clear_i(clear_i), .c_out_i(c_out2), .req_a_o(req_a2), .req_b_o(req_b2),
    .busy_o(busy2), .done_cnt_o(done2), .err_hold_o(hold2), .err_timeout_o(tmo2)
  );

  // C-element models with one cycle of delay
  always @(posedge clk or posedge rst) begin
    if (rst) c_good1 <= 1'b0;
    else if (req_a1 && req_b1) c_good1 <= 1'b1;
    else if (!req_a1 && !req_b1) c_good1 <= 1'b0;
  end
  always @(posedge clk or posedge rst) begin
    if (rst) c_good2 <= 1'b0;
    else if (req_a2 && req_b2) c_good2 <= 1'b1;
    else if (!req_a2 && !req_b2) c_good2 <= 1'b0;
  end

  assign c_out1 = (fault_mode == 2'd0) ? c_good1 : (fault_mode == 2'd1) ? req_a1 : 1'b0;
  assign c_out2 = c_good2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one handshake from the cycle after req_a rises. Expected req/busy levels come from
  // the timeline: req_a high for s+5 cycles, req_b from s+1 to 2s+5, next start at 2s+10.
  task automatic run_hs(input logic [3:0] s, input logic [3:0] junk, input bit keep,
                        input logic [3:0] next_s, output int a_hi, output int b_dly,
                        output int per);
    int  si;
    int  k;
    bit  prev_a;
    bit  fin;
    logic exp_a, exp_b;
    si = int'(s);
    a_hi = 0; b_dly = -1; k = 0; fin = 1'b0;
    while (!fin && k < 100) begin
      exp_a = (k < si + 5);
      exp_b = (k >= si + 1) && (k < 2 * si + 6);
      check("hs_levels", {29'd0, req_a1, req_b1, busy1}, {29'd0, exp_a, exp_b, 1'b1});
      if (req_a1) a_hi++;
      if (req_b1 && b_dly < 0) b_dly = k;
      if (k == 1) skew_i = junk;
      if (k == si + 2 && !keep) enable_i = 1'b0;
      if (k == si + 6) skew_i = next_s;
      prev_a = req_a1;
      step();
      k++;
      if (!busy1 || (req_a1 && !prev_a)) fin = 1'b1;
    end
    per = k;
    if (!fin) check("hs_bound", 32'(k), 32'd0);
  endtask

  typedef struct {
    logic [3:0] skew;
    logic [3:0] junk;
    bit         keep;
    int         a_hi;
    int         b_dly;
    int         per;
  } hs_vec_t;

  hs_vec_t    tbl[6];
  logic [3:0] rs[11];
  int a_hi, b_dly, per;
  int base;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'd0,  4'd9, 1'b1, 5,  1,  10};
    tbl[1] = '{4'd0,  4'd15, 1'b1, 5,  1,  10};
    tbl[2] = '{4'd0,  4'd3, 1'b1, 5,  1,  10};
    tbl[3] = '{4'd3,  4'd0, 1'b1, 8,  4,  16};
    tbl[4] = '{4'd15, 4'd2, 1'b1, 20, 16, 40};
    tbl[5] = '{4'd1,  4'd7, 1'b0, 6,  2,  12};

    rst = 1'b1; enable_i = 1'b0; skew_i = 4'd0; clear_i = 1'b0; fault_mode = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_reqs", {30'd0, req_a1, req_b1}, 32'd0);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_done", {16'd0, done1}, 32'd0);
    check("rst_flags", {30'd0, hold1, tmo1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Table-driven handshakes, last one drops enable in RISE_B
    skew_i = tbl[0].skew;
    enable_i = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      check("tbl_done", {16'd0, done1}, 32'(i));
      run_hs(tbl[i].skew, tbl[i].junk, tbl[i].keep,
             (i < 5) ? tbl[i + 1].skew : 4'd0, a_hi, b_dly, per);
      check("tbl_a_hi", 32'(a_hi), 32'(tbl[i].a_hi));
      check("tbl_b_dly", 32'(b_dly), 32'(tbl[i].b_dly));
      check("tbl_period", 32'(per), 32'(tbl[i].per));
    end
    for (int j = 0; j < 3; j++) begin
      check("drop_idle", {30'd0, req_a1, busy1}, 32'd0);
      step();
    end
    check("drop_done", {16'd0, done1}, 32'd6);
    check("drop_flags", {30'd0, hold1, tmo1}, 32'd0);
    check("wrap_done", {30'd0, done2}, 32'd2);
    check("wrap_flags", {30'd0, hold2, tmo2}, 32'd0);

    // Randomized skews checked against the timeline model
    for (int i = 0; i < 11; i++) rs[i] = 4'($urandom_range(0, 15));
    base = 6;
    skew_i = rs[0];
    enable_i = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      check("rnd_done", {16'd0, done1}, 32'(base + i));
      run_hs(rs[i], 4'($urandom_range(0, 15)), 1'b1, rs[i + 1], a_hi, b_dly, per);
      check("rnd_period", 32'(per), 32'(2 * int'(rs[i]) + 10));
    end
    check("rnd_done_end", {16'd0, done1}, 32'd16);
    check("rnd_wrap", {30'd0, done2}, 32'd0);

    // Asynchronous reset in the middle of a handshake
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    check("arst_reqs", {30'd0, req_a1, req_b1}, 32'd0);
    check("arst_busy", {31'd0, busy1}, 32'd0);
    check("arst_done", {16'd0, done1}, 32'd0);
    check("arst_flags", {30'd0, hold1, tmo1}, 32'd0);
    enable_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();

    // Hold violation: C output follows req_a alone
    fault_mode = 2'd1;
    skew_i = 4'd5;
    enable_i = 1'b1;
    step();
    check("hold_start", {31'd0, req_a1}, 32'd1);
    step();
    step();
    check("hold_early", {30'd0, hold1, busy1}, 32'd1);
    step();
    enable_i = 1'b0;
    check("hold_flag", {31'd0, hold1}, 32'd1);
    check("hold_reqs", {29'd0, req_a1, req_b1, busy1}, 32'd0);
    check("hold_done", {16'd0, done1}, 32'd0);
    repeat (3) step();
    check("hold_sticky", {30'd0, hold1, tmo1}, 32'd2);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    check("hold_clear", {29'd0, hold1, tmo1, busy1}, 32'd0);

    // Timeout: C output stuck low; a clear pulse mid-wait must be ignored
    fault_mode = 2'd2;
    skew_i = 4'd0;
    enable_i = 1'b1;
    step();
    enable_i = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (k == 100) clear_i = 1'b1;
      if (k == 101) clear_i = 1'b0;
      step();
    end
    check("tmo_before", {29'd0, tmo1, busy1, req_b1}, 32'd3);
    step();
    check("tmo_flag", {30'd0, tmo1, hold1}, 32'd2);
    check("tmo_reqs", {29'd0, req_a1, req_b1, busy1}, 32'd0);
    repeat (2) step();
    check("tmo_sticky", {31'd0, tmo1}, 32'd1);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    check("tmo_clear", {29'd0, hold1, tmo1, busy1}, 32'd0);

    // After clear the sequencer is idle and starts a fresh handshake
    fault_mode = 2'd0;
    enable_i = 1'b1;
    step();
    enable_i = 1'b0;
    check("post_clear_start", {30'd0, req_a1, busy1}, 32'd3);
    repeat (15) step();
    check("post_clear_done", {16'd0, done1}, 32'd1);
    check("post_clear_idle", {29'd0, busy1, hold1, tmo1}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
